// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ: filters PPU A12 rises, counts scanlines, raises an active-low IRQ.
// Define MMC3_IRQ_ALT_EN to select the old-revision trigger, which stays silent on reload-to-zero.
module mmc3_scanline_irq #(
  parameter int A12_LOW_MIN     = 3,
  parameter int A12_SYNC_STAGES = 2
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cpu_wr_stb,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq,
  output logic [7:0]  irq_counter
);
  localparam int LW = $clog2(A12_LOW_MIN + 1);

  logic [A12_SYNC_STAGES-1:0] r_sync;
  logic                       r_a12_prev;
  logic [LW-1:0]              r_low_cnt;
  logic [7:0]                 r_latch, r_counter;
  logic                       r_reload, r_irq_en, r_irq_pend, r_irq;

  logic       w_a12_s, w_event, w_wr, w_c000, w_c001, w_e000, w_e001, w_trig;
  logic [7:0] w_new;

  assign w_a12_s = r_sync[A12_SYNC_STAGES-1];
  // A rise only counts after A12 has been quiet long enough; this rejects the
  // short A12 toggles of sprite/background fetch interleaving.
  assign w_event = w_a12_s && !r_a12_prev && (r_low_cnt >= LW'(A12_LOW_MIN));

  assign w_wr   = cpu_wr_stb && enable && cpu_addr_in[14];
  assign w_c000 = w_wr && !cpu_addr_in[13] && !cpu_addr_in[0];
  assign w_c001 = w_wr && !cpu_addr_in[13] &&  cpu_addr_in[0];
  assign w_e000 = w_wr &&  cpu_addr_in[13] && !cpu_addr_in[0];
  assign w_e001 = w_wr &&  cpu_addr_in[13] &&  cpu_addr_in[0];

  assign w_new = (r_counter == 8'd0 || r_reload) ? r_latch : r_counter - 8'd1;

`ifdef MMC3_IRQ_ALT_EN
  assign w_trig = (w_new == 8'd0) && r_irq_en && (r_counter != 8'd0 || r_reload);
`else
  assign w_trig = (w_new == 8'd0) && r_irq_en;
`endif

  always_ff @(posedge m2) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_a12_prev <= 1'b0;
      r_low_cnt  <= '0;
      r_latch    <= 8'd0;
      r_counter  <= 8'd0;
      r_reload   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
      r_irq      <= 1'b1;
    end else begin
      r_sync     <= {r_sync[A12_SYNC_STAGES-2:0], ppu_a12};
      r_a12_prev <= w_a12_s;
      if (w_a12_s)
        r_low_cnt <= '0;
      else if (r_low_cnt < LW'(A12_LOW_MIN))
        r_low_cnt <= r_low_cnt + LW'(1);

      r_irq <= ~(r_irq_pend && enable);

      // Register writes come after the event update so they win on collision.
      if (enable) begin
        if (w_event && !w_c001) begin
          r_counter <= w_new;
          r_reload  <= 1'b0;
          if (w_trig) r_irq_pend <= 1'b1;
        end
        if (w_c000) r_latch <= cpu_data_in;
        if (w_c001) begin
          r_counter <= 8'd0;
          r_reload  <= 1'b1;
        end
        if (w_e000) begin
          r_irq_en   <= 1'b0;
          r_irq_pend <= 1'b0;
        end
        if (w_e001) r_irq_en <= 1'b1;
      end
    end
  end

  assign irq         = r_irq;
  assign irq_counter = r_counter;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Scoreboard bench for mmc3_scanline_irq: stimulus queues expected outputs, a negedge monitor checks them.
module tb_mmc3_scanline_irq;
  logic        m2 = 1'b0;
  logic        rst_n, enable, cpu_wr_stb, ppu_a12;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        irq;
  logic [7:0]  irq_counter;

  mmc3_scanline_irq dut (
    .m2(m2), .rst_n(rst_n), .enable(enable), .cpu_wr_stb(cpu_wr_stb),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
    .irq(irq), .irq_counter(irq_counter)
  );

  always #5 m2 = ~m2;

  typedef struct { string name; logic [7:0] cnt; logic irq; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

`ifdef MMC3_IRQ_ALT_EN
  localparam logic ALT = 1'b1;
`else
  localparam logic ALT = 1'b0;
`endif

  always @(negedge m2) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (irq_counter !== mon_e.cnt || irq !== mon_e.irq) begin
        failures++;
        $display("FAIL %s: got cnt=%0d irq=%b, want cnt=%0d irq=%b",
                 mon_e.name, irq_counter, irq, mon_e.cnt, mon_e.irq);
      end
    end
  end

  task automatic tick();
    @(posedge m2); #1;
  endtask

  task automatic expect_out(input string n, input logic [7:0] c, input logic i);
    q.push_back('{n, c, i});
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr_in = a[14:0]; cpu_data_in = d; cpu_wr_stb = 1'b1;
    tick();
    cpu_wr_stb = 1'b0;
  endtask

  task automatic pulse(input int lo, input int hi);
    ppu_a12 = 1'b0; repeat (lo) tick();
    ppu_a12 = 1'b1; repeat (hi) tick();
  endtask

  // Lands the register write on the event edge (third edge after the rise).
  task automatic pulse_wr(input int lo, input logic [15:0] a, input logic [7:0] d);
    ppu_a12 = 1'b0; repeat (lo) tick();
    ppu_a12 = 1'b1; tick(); tick();
    wr(a, d);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; cpu_wr_stb = 1'b0; ppu_a12 = 1'b0;
    cpu_addr_in = '0; cpu_data_in = '0;
    tick(); ppu_a12 = 1'b1; expect_out("rst_hold0", 8'd0, 1'b1);
    tick(); ppu_a12 = 1'b0; expect_out("rst_hold1", 8'd0, 1'b1);
    rst_n = 1'b1;
    tick(); expect_out("idle", 8'd0, 1'b1);

    // basic count 3,2,1,0
    wr(16'hC000, 8'd3); wr(16'hC001, 8'd0); expect_out("c001_clr", 8'd0, 1'b1);
    wr(16'hE001, 8'd0);
    pulse(4, 4); expect_out("cnt3", 8'd3, 1'b1);
    pulse(4, 4); expect_out("cnt2", 8'd2, 1'b1);
    pulse(4, 4); expect_out("cnt1", 8'd1, 1'b1);
    pulse(4, 4); expect_out("cnt0_irq", 8'd0, 1'b0);
    wr(16'hE000, 8'd0); expect_out("e000_lag", 8'd0, 1'b0);
    tick(); expect_out("e000_ack", 8'd0, 1'b1);

    // filter
    pulse(2, 4); expect_out("flt_low2", 8'd0, 1'b1);
    pulse(3, 4); expect_out("flt_low3", 8'd3, 1'b1);
    pulse(3, 10); expect_out("flt_hold", 8'd2, 1'b1);

    // collisions
    pulse_wr(3, 16'hC001, 8'd0); expect_out("col_c001", 8'd0, 1'b1);
    pulse(4, 4); expect_out("col_c001_rl", 8'd3, 1'b1);
    wr(16'hE001, 8'd0);
    pulse(4, 4); expect_out("pre_e000_2", 8'd2, 1'b1);
    pulse(4, 4); expect_out("pre_e000_1", 8'd1, 1'b1);
    pulse_wr(3, 16'hE000, 8'd0); expect_out("col_e000", 8'd0, 1'b1);
    tick(); expect_out("col_e000_hold", 8'd0, 1'b1);
    pulse_wr(3, 16'hC000, 8'd7); expect_out("col_c000_old", 8'd3, 1'b1);
    wr(16'hC001, 8'd0);
    pulse(4, 4); expect_out("col_c000_new", 8'd7, 1'b1);
    wr(16'hC000, 8'd0); wr(16'hC001, 8'd0);
    pulse_wr(3, 16'hE001, 8'd0); expect_out("col_e001", 8'd0, 1'b1);

    // latch=0 with irq enabled
    pulse(4, 4); expect_out("l0_rise1", 8'd0, ALT);
    wr(16'hE000, 8'd0); tick(); expect_out("l0_ack1", 8'd0, 1'b1);
    wr(16'hE001, 8'd0);
    pulse(4, 4); expect_out("l0_rise2", 8'd0, ALT);
    wr(16'hE000, 8'd0); tick();
    wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    pulse(4, 4); expect_out("l0_after_c001", 8'd0, 1'b0);
    wr(16'hE000, 8'd0); tick(); expect_out("l0_ack3", 8'd0, 1'b1);

    // gating
    wr(16'hC000, 8'd5); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    pulse(4, 4); expect_out("g_cnt5", 8'd5, 1'b1);
    pulse(4, 4); expect_out("g_cnt4", 8'd4, 1'b1);
    enable = 1'b0;
    pulse(4, 4); expect_out("g_frozen", 8'd4, 1'b1);
    wr(16'hC001, 8'd0); expect_out("g_wr_ign", 8'd4, 1'b1);
    enable = 1'b1;
    pulse(4, 4); expect_out("g_cnt3", 8'd3, 1'b1);
    pulse(4, 4); pulse(4, 4);
    pulse(4, 4); expect_out("g_irq", 8'd0, 1'b0);
    enable = 1'b0; tick(); expect_out("g_irq_mask", 8'd0, 1'b1);
    enable = 1'b1; tick(); expect_out("g_pend_kept", 8'd0, 1'b0);

    // reset mid-operation
    rst_n = 1'b0; tick(); expect_out("rst_mid", 8'd0, 1'b1);
    rst_n = 1'b1;
    wr(16'hC001, 8'd0);
    pulse(4, 4); expect_out("rst_latch0", 8'd0, 1'b1);

    tick(); tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmc3_scanline_irq.md
Name: mmc3_scanline_irq

Overview:
- MMC3-style scanline IRQ generator; sits in the mapper layer and drives the cartridge `irq` pin of the CoolGirl top level.
- Consumes CPU register writes (the $C000-$FFFF, romsel-low window) and the raw PPU A12 line.
- Filters A12 rising edges, counts scanlines, and asserts an active-low IRQ when the counter reaches zero while enabled.
- Active only when the multicart mapper selection enables it.

Parameters:
- A12_LOW_MIN, 3: consecutive m2 cycles synchronised A12 must be low before a rise counts as a scanline clock.
- A12_SYNC_STAGES, 2: synchroniser depth for ppu_a12; legal values 2..3.

Ports:
- m2  input  1  CPU M2; sole clock, rising-edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising m2.
- enable  input  1  mapper-select gate; 1 = block active.
- cpu_wr_stb  input  1  one-cycle write strobe from the upstream decoder (romsel low, cpu_rw_in low), aligned to m2.
- cpu_addr_in  input  15  CPU A14..A0.
- cpu_data_in  input  8  CPU write data.
- ppu_a12  input  1  raw PPU address bit 12; asynchronous to m2.
- irq  output  1  active-low IRQ; 1 = idle.
- irq_counter  output  8  current counter value, for debug and readback.

Behaviour:
- Reset (rst_n=0 at a rising m2 edge):
  - latch=0, counter=0, reload=0, irq_en=0, irq_pend=0.
  - low_cnt=0; synchroniser flops cleared to 0.
  - Outputs: irq=1, irq_counter=0.
  - Reset mid-operation discards any pending event.
- Register decode: acts only when cpu_wr_stb=1, enable=1 and cpu_addr_in[14]=1.
  - A13=0, A0=0 ($C000): latch <= data.
  - A13=0, A0=1 ($C001): counter <= 0, reload <= 1.
  - A13=1, A0=0 ($E000): irq_en <= 0, irq_pend <= 0 (disable + acknowledge).
  - A13=1, A0=1 ($E001): irq_en <= 1; irq_pend unchanged.
  - Writes with A14=0 are ignored.
- A12 filter:
  - a12_s = ppu_a12 after A12_SYNC_STAGES flops.
  - low_cnt counts cycles with a12_s=0, saturating at A12_LOW_MIN. It clears on any cycle with a12_s=1.
  - Event asserts for exactly one cycle when a12_s=1, previous a12_s=0, and low_cnt>=A12_LOW_MIN.
  - Latency: ppu_a12 rise to counter update = A12_SYNC_STAGES+1 m2 edges.
- Counter, on an event cycle:
  - if counter==0 or reload==1: counter <= latch, reload <= 0;
  - else: counter <= counter-1 (8-bit, never wraps below 0 because 0 triggers a reload).
  - new_value is the value written in that same cycle.
  - Default trigger: if new_value==0 and irq_en=1, irq_pend <= 1 in the same edge.
- irq = ~irq_pend, registered. It asserts one cycle after the event edge is visible at the flop output; no combinational path from inputs.
- irq_pend is sticky until $E000 or reset.
- latch=0: every event reloads to 0. With irq_en=1, IRQ fires on every filtered rise.
- Simultaneous events:
  - $C001 write + event: write wins, event dropped, counter=0, reload=1.
  - $C000 write + event: event uses the old latch.
  - $E000 write + event: irq_pend ends 0 and irq_en ends 0; the counter still updates.
  - $E001 write + event: the event uses the old irq_en.
- enable=0: writes ignored, counter/latch frozen, filter keeps tracking, irq forced to 1 (irq_pend retained).

Optional Feature:
- Macro: MMC3_IRQ_ALT_EN.
- Defined: alternate (old-revision) trigger. irq_pend sets only if new_value==0, irq_en=1, AND (old counter != 0 OR reload was 1).
  - Consequence: with latch=0, only the first event after a $C001 write fires; later reloads to 0 stay silent.
- Undefined: default trigger as in Behaviour.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, toggle ppu_a12 -> irq=1, irq_counter=0 throughout.
- Basic count: write $C000=3, $C001, $E001; then feed filtered A12 rises.
  - Counter sequence: 3, 2, 1, 0.
  - irq falls after the 4th rise.
  - $E000 write -> irq=1 next cycle, irq_en=0.
- Filter: A12 low for 2 cycles then high -> no counter change; low for 3 cycles then high -> one decrement.
  - A12 held high for 10 cycles -> exactly one event.
- Collisions:
  - $C001 write on the event cycle -> counter=0, reload=1, no decrement.
  - $E000 on an event cycle that reaches 0 -> irq stays 1.
- latch=0 with $E001:
  - Default: irq asserts after every rise, re-asserting after each $E000.
  - With MMC3_IRQ_ALT_EN: only the first rise after $C001 asserts irq.
- Gating/reset: enable=0 during a count -> counter frozen, irq=1. rst_n=0 mid-count with irq asserted -> next cycle irq=1, counter=0, latch=0.
